jtag_dtm_sampler: RTL

- Simulation-side JTAG Debug Transport Module. Sits directly downstream of the DPI JTAG bit-banger and consumes its jtag_TCK/TMS/TDI/TRSTn; drives jtag_TDO_data/jtag_TDO_driven back to it.
- Oversamples JTAG pins in the system clock domain and runs the IEEE 1149.1 TAP FSM.
- Implements IDCODE, DTMCS, DMI and BYPASS registers; converts DMI scans into a valid/ready request/response interface toward the debug module.

---
 rtl/jtag_dtm_sampler_if.sv | 24 ++
 rtl/jtag_dtm_sampler.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/jtag_dtm_sampler_if.sv
// DMI request/response bus between the JTAG DTM (master) and the debug module (slave).
interface jtag_dtm_sampler_if #(
   parameter int ABITS = 7
);
   logic             dmi_req_valid;
   logic             dmi_req_ready;
   logic [ABITS-1:0] dmi_req_addr;
   logic [31:0]      dmi_req_data;
   logic [1:0]       dmi_req_op;
   logic             dmi_resp_valid;
   logic             dmi_resp_ready;
   logic [31:0]      dmi_resp_data;
   logic [1:0]       dmi_resp_resp;

   modport master (
      output dmi_req_valid, dmi_req_addr, dmi_req_data, dmi_req_op, dmi_resp_ready,
      input  dmi_req_ready, dmi_resp_valid, dmi_resp_data, dmi_resp_resp
   );

   modport slave (
      input  dmi_req_valid, dmi_req_addr, dmi_req_data, dmi_req_op, dmi_resp_ready,
      output dmi_req_ready, dmi_resp_valid, dmi_resp_data, dmi_resp_resp
   );
endinterface

// File: rtl/jtag_dtm_sampler.sv
// JTAG DTM that oversamples the TAP pins in the system clock domain and bridges
// DMI scans onto a valid/ready request/response bus.
module jtag_dtm_sampler #(
   parameter int          ABITS       = 7,
   parameter logic [31:0] IDCODE      = 32'h0000_0001,
   parameter int          SYNC_STAGES = 2
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               jtag_TCK,
   input  logic               jtag_TMS,
   input  logic               jtag_TDI,
   input  logic               jtag_TRSTn,
   output logic               jtag_TDO_data,
   output logic               jtag_TDO_driven,
   jtag_dtm_sampler_if.master dmi
);
   localparam int DRW = ABITS + 34;
   localparam logic [4:0] IR_IDCODE = 5'h01;
   localparam logic [4:0] IR_DTMCS  = 5'h10;
   localparam logic [4:0] IR_DMI    = 5'h11;

   typedef enum logic [3:0] {
      TLR, RTI, SEL_DR, CAP_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPD_DR,
      SEL_IR, CAP_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPD_IR
   } tap_state_t;

   logic [SYNC_STAGES-1:0] tck_sync, tms_sync, tdi_sync, trstn_sync;
   logic                   tck_prev;
   logic                   tck_s, tms_s, tdi_s, trstn_s;
   logic                   tck_rise, tck_fall;
   tap_state_t             state;
   logic [4:0]             ir, ir_shift;
   logic [DRW-1:0]         dr_shift, dr_cap, dr_shifted;
   logic                   busy, acked, discard;
   logic [1:0]             sticky;
   logic [ABITS-1:0]       last_addr;
   logic [31:0]            resp_data_q;
   logic                   upd_dr, req_fire;

   function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
      case (s)
         TLR:      return tms ? TLR      : RTI;
         RTI:      return tms ? SEL_DR   : RTI;
         SEL_DR:   return tms ? SEL_IR   : CAP_DR;
         CAP_DR:   return tms ? EXIT1_DR : SHIFT_DR;
         SHIFT_DR: return tms ? EXIT1_DR : SHIFT_DR;
         EXIT1_DR: return tms ? UPD_DR   : PAUSE_DR;
         PAUSE_DR: return tms ? EXIT2_DR : PAUSE_DR;
         EXIT2_DR: return tms ? UPD_DR   : SHIFT_DR;
         UPD_DR:   return tms ? SEL_DR   : RTI;
         SEL_IR:   return tms ? TLR      : CAP_IR;
         CAP_IR:   return tms ? EXIT1_IR : SHIFT_IR;
         SHIFT_IR: return tms ? EXIT1_IR : SHIFT_IR;
         EXIT1_IR: return tms ? UPD_IR   : PAUSE_IR;
         PAUSE_IR: return tms ? EXIT2_IR : PAUSE_IR;
         EXIT2_IR: return tms ? UPD_IR   : SHIFT_IR;
         UPD_IR:   return tms ? SEL_DR   : RTI;
         default:  return TLR;
      endcase
   endfunction

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         tck_sync   <= '0;
         tms_sync   <= '1;
         tdi_sync   <= '0;
         trstn_sync <= '0;
         tck_prev   <= 1'b0;
      end else begin
         tck_sync   <= {tck_sync[SYNC_STAGES-2:0], jtag_TCK};
         tms_sync   <= {tms_sync[SYNC_STAGES-2:0], jtag_TMS};
         tdi_sync   <= {tdi_sync[SYNC_STAGES-2:0], jtag_TDI};
         trstn_sync <= {trstn_sync[SYNC_STAGES-2:0], jtag_TRSTn};
         tck_prev   <= tck_s;
      end
   end

   assign tck_s    = tck_sync[SYNC_STAGES-1];
   assign tms_s    = tms_sync[SYNC_STAGES-1];
   assign tdi_s    = tdi_sync[SYNC_STAGES-1];
   assign trstn_s  = trstn_sync[SYNC_STAGES-1];
   assign tck_rise = tck_s & ~tck_prev;
   assign tck_fall = ~tck_s & tck_prev;

   // Capture value and shifted value of the DR selected by the current IR.
   always_comb begin
      dr_cap     = '0;
      dr_shifted = {{(DRW-1){1'b0}}, tdi_s};
      case (ir)
         IR_IDCODE: begin
            dr_cap     = {{(DRW-32){1'b0}}, IDCODE};
            dr_shifted = {{(DRW-32){1'b0}}, tdi_s, dr_shift[31:1]};
         end
         IR_DTMCS: begin
            dr_cap     = {{(DRW-32){1'b0}}, 17'b0, 3'd1, sticky, 6'(ABITS), 4'd1};
            dr_shifted = {{(DRW-32){1'b0}}, tdi_s, dr_shift[31:1]};
         end
         IR_DMI: begin
            dr_cap     = {last_addr, resp_data_q, (busy ? 2'd3 : sticky)};
            dr_shifted = {tdi_s, dr_shift[DRW-1:1]};
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state           <= TLR;
         ir              <= IR_IDCODE;
         ir_shift        <= '0;
         dr_shift        <= '0;
         jtag_TDO_data   <= 1'b0;
         jtag_TDO_driven <= 1'b0;
      end else begin
         if (tck_fall) begin
            jtag_TDO_data   <= (state >= SEL_IR) ? ir_shift[0] : dr_shift[0];
            jtag_TDO_driven <= (state == SHIFT_IR) || (state == SHIFT_DR);
         end
         if (!trstn_s) begin
            state <= TLR;
            ir    <= IR_IDCODE;
         end else begin
            if (tck_rise) begin
               state <= tap_next(state, tms_s);
               case (state)
                  CAP_IR:   ir_shift <= 5'b00001;
                  SHIFT_IR: ir_shift <= {tdi_s, ir_shift[4:1]};
                  CAP_DR:   dr_shift <= dr_cap;
                  SHIFT_DR: dr_shift <= dr_shifted;
                  default: ;
               endcase
            end
            if (tck_fall && state == UPD_IR) ir <= ir_shift;
            if (state == TLR) ir <= IR_IDCODE;
         end
      end
   end

   assign upd_dr             = tck_fall && trstn_s && (state == UPD_DR);
   assign req_fire           = dmi.dmi_req_valid && dmi.dmi_req_ready;
   assign dmi.dmi_resp_ready = 1'b1;

   // Later assignments win, so a busy error (3) overrides a same-clock response failure.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         dmi.dmi_req_valid <= 1'b0;
         dmi.dmi_req_addr  <= '0;
         dmi.dmi_req_data  <= '0;
         dmi.dmi_req_op    <= '0;
         busy              <= 1'b0;
         acked             <= 1'b0;
         discard           <= 1'b0;
         sticky            <= '0;
         last_addr         <= '0;
         resp_data_q       <= '0;
      end else begin
         if (req_fire) begin
            dmi.dmi_req_valid <= 1'b0;
            acked             <= 1'b1;
         end
         if (dmi.dmi_resp_valid) begin
            if (discard) begin
               discard <= 1'b0;
            end else if (busy && acked) begin
               resp_data_q <= dmi.dmi_resp_data;
               if (dmi.dmi_resp_resp != 2'd0 && sticky == 2'd0) sticky <= 2'd2;
               busy  <= 1'b0;
               acked <= 1'b0;
            end
         end
         if (upd_dr && ir == IR_DTMCS) begin
            if (dr_shift[16] || dr_shift[17]) sticky <= 2'd0;
            if (dr_shift[17]) begin
               busy              <= 1'b0;
               acked             <= 1'b0;
               dmi.dmi_req_valid <= 1'b0;
               discard           <= busy && (acked || req_fire);
            end
         end
         if (upd_dr && ir == IR_DMI) begin
            if (busy) begin
               sticky <= 2'd3;
            end else if (sticky == 2'd0 && (dr_shift[1:0] == 2'd1 || dr_shift[1:0] == 2'd2)) begin
               dmi.dmi_req_valid <= 1'b1;
               dmi.dmi_req_addr  <= dr_shift[DRW-1:34];
               dmi.dmi_req_data  <= dr_shift[33:2];
               dmi.dmi_req_op    <= dr_shift[1:0];
               last_addr         <= dr_shift[DRW-1:34];
               busy              <= 1'b1;
            end
         end
      end
   end
endmodule
